gp_counter_reg: RTL

GP_COUNTER_REG -- requirements
Module: gp_counter_reg

---
 rtl/gp_counter_reg.sv | 117 +++++++++++
 1 files changed

// File: rtl/gp_counter_reg.sv
// General-purpose counter/shift register with overflow, wrap and compare flags.
// Latency: every operation takes effect on the falling CLK edge, and REG_OUT and the flags show the result right after it.
// Backpressure: none. A control can act on every falling edge, and no control is ever stalled.
//
// Ports:
//   CLK      clock; all state changes on the falling edge
//   reset    asynchronous active-high reset; loads RESET_VAL and clears all flags
//   CLR      clears the register and all flags
//   LD       loads REG_INP into the register
//   INC      increments the register by one
//   DEC      decrements the register by one
//   SHL      shifts left; SI enters at the bottom bit
//   SHR      shifts right; SI enters at the top bit
//   SI       serial shift-in bit
//   REG_INP  parallel load data
//   CMP_VAL  compare value for MATCH
//   REG_OUT  register contents
//   ZERO     combinational; high while REG_OUT is zero
//   OVF      sticky over/underflow flag; only CLR and reset clear it
//   WRAP     one-cycle pulse after a wrap-around edge
//   MATCH    high after an INC/DEC edge whose result equals CMP_VAL
// Operation priority: CLR > LD > INC/DEC > SHL/SHR > hold.
module gp_counter_reg #(
    parameter int unsigned      WIDTH     = 16,
    parameter bit               SATURATE  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             CLR,
    input  logic             LD,
    input  logic             INC,
    input  logic             DEC,
    input  logic             SHL,
    input  logic             SHR,
    input  logic             SI,
    input  logic [WIDTH-1:0] REG_INP,
    input  logic [WIDTH-1:0] CMP_VAL,
    output logic [WIDTH-1:0] REG_OUT,
    output logic             ZERO,
    output logic             OVF,
    output logic             WRAP,
    output logic             MATCH
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_next;
    logic             count_op;
    logic             at_limit;
    logic             wraps;
    logic             ovf_q;
    logic             wrap_q;
    logic             match_q;

    // Next count for a single INC or DEC. At_limit means the step would
    // cross the all-ones or zero boundary in the requested direction.
    always_comb begin
        count_op   = INC ^ DEC;
        at_limit   = INC ? (count_q == ALL_ONES) : (count_q == '0);
        wraps      = count_op && at_limit && !SATURATE;
        count_next = count_q;
        if (!at_limit) begin
            count_next = INC ? (count_q + ONE) : (count_q - ONE);
        end else if (!SATURATE) begin
            count_next = INC ? '0 : ALL_ONES;
        end
    end

    always_ff @(negedge CLK or posedge reset) begin
        if (reset) begin
            count_q <= RESET_VAL;
            ovf_q   <= 1'b0;
            wrap_q  <= 1'b0;
            match_q <= 1'b0;
        end else if (CLR) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            wrap_q  <= 1'b0;
            match_q <= 1'b0;
        end else if (LD) begin
            count_q <= REG_INP;
            wrap_q  <= 1'b0;
            match_q <= 1'b0;
        end else if (count_op) begin
            count_q <= count_next;
            wrap_q  <= wraps;
            match_q <= (count_next == CMP_VAL);
            // Saturating at the boundary also counts as over/underflow.
            if (at_limit) begin
                ovf_q <= 1'b1;
            end
        end else if (INC && DEC) begin
            // Opposing count requests cancel. The register, OVF and MATCH
            // hold, and the shift controls are ignored. WRAP still drops so
            // that it stays a single-cycle pulse.
            wrap_q <= 1'b0;
        end else begin
            wrap_q  <= 1'b0;
            match_q <= 1'b0;
            if (SHL && !SHR) begin
                count_q <= {count_q[WIDTH-2:0], SI};
            end else if (SHR && !SHL) begin
                count_q <= {SI, count_q[WIDTH-1:1]};
            end
        end
    end

    assign REG_OUT = count_q;
    assign ZERO    = (count_q == '0);
    assign OVF     = ovf_q;
    assign WRAP    = wrap_q;
    assign MATCH   = match_q;

endmodule
